fetch_unit: RTL

Instruction fetch stage for the ARMv8 datapath. It holds the program counter and requests instruction words from instruction memory over a req/ack handshake. It presents each fetched word to decode over a valid/ready handshake and drives `Imm26` (instruction bits 25:0) to the sign extender. It consumes the 64-bit `BusImm` returned by the sign extender to compute branch targets (PC-relative, word-scaled).

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: instruction-memory request/ack side and the
// decode/sign-extender side of the fetch unit.
interface fetch_unit_if;
    // Instruction memory side
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Decode / sign-extender side
    logic [31:0] Instruction;
    logic [25:0] Imm26;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] BusImm;
    logic        Branch;
    logic        Uncondbranch;
    logic        Zero;
    logic [63:0] PC;

    // Fetch unit view
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output Instruction, Imm26, inst_valid, PC,
        input  inst_ready, BusImm, Branch, Uncondbranch, Zero
    );

    // Memory / decode view
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  Instruction, Imm26, inst_valid, PC,
        output inst_ready, BusImm, Branch, Uncondbranch, Zero
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// level req/ack handshake and hands it to decode over valid/ready.  The next
// PC is either sequential (+4) or a word-scaled PC-relative branch target.
module fetch_unit (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] startPC,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        req;
    logic        valid;
    logic        fetch_done;
    logic        accept;
    logic        take_branch;
    logic [63:0] pc_next;

    // Branch offsets are signed word counts; modulo-2^64 add lets negative
    // offsets branch backward without any special handling.
    function automatic logic [63:0] branch_target(input logic [63:0] base,
                                                  input logic signed [63:0] offset);
        logic signed [63:0] scaled;
        scaled = offset <<< 2;
        return base + $unsigned(scaled);
    endfunction

    function automatic logic [63:0] seq_target(input logic [63:0] base);
        return base + 64'd4;
    endfunction

    assign fetch_done  = (state == S_WAIT) && bus.imem_ack;
    assign accept      = (state == S_HOLD) && bus.inst_ready;
    assign take_branch = bus.Uncondbranch | (bus.Branch & bus.Zero);
    assign pc_next     = take_branch ? branch_target(pc, $signed(bus.BusImm))
                                     : seq_target(pc);

    // State register; reset wins over any handshake in flight.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; ack/ready outside their state are ignored.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        valid      = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                valid = 1'b1;
                if (bus.inst_ready) begin
                    state_next = S_WAIT;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // PC and instruction registers; both frozen except on fetch/accept edges.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            pc    <= startPC;
            instr <= 32'd0;
        end else begin
            if (fetch_done) begin
                instr <= bus.imem_rdata;
            end
            if (accept) begin
                pc <= pc_next;
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.PC          = pc;
    assign bus.Instruction = instr;
    assign bus.Imm26       = instr[25:0];
    assign bus.inst_valid  = valid;

endmodule
